// File: rtl/sb_init_pattern_ctrl.sv
// Sideband clock-pattern engine for SBINIT: sends pattern word + low gap repeatedly,
// detects the partner's pattern, sends EXTRA_ITER more iterations, then signals done.
// Latency: TX valid the cycle after req; all outputs registered. Backpressure: word held until i_tx_ready.
//
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_sbinit_en               SBINIT enable from LTSM; low returns to IDLE next cycle
//   i_start_pattern_req       1-cycle start pulse from TX SBINIT FSM (ignored outside IDLE)
//   i_tx_ready                serializer accepts o_tx_data when o_tx_valid is high
//   i_rx_valid, i_rx_data     deserialized partner words
//   o_tx_valid, o_tx_data     pattern word to serializer (data is 0 when not valid)
//   o_start_pattern_done      high only in DONE
//   o_pattern_timeout         high only in TIMEOUT
//   o_partner_detected        sticky detect flag, cleared in IDLE
module sb_init_pattern_ctrl #(
    parameter int              DW             = 64,
    parameter logic [DW-1:0]   PATTERN        = {(DW/2){2'b10}},
    parameter int              GAP_CYCLES     = 1,
    parameter int              DETECT_COUNT   = 2,
    parameter int              EXTRA_ITER     = 4,
    parameter int              TIMEOUT_CYCLES = 800000
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sbinit_en,
    input  logic          i_start_pattern_req,
    input  logic          i_tx_ready,
    input  logic          i_rx_valid,
    input  logic [DW-1:0] i_rx_data,
    output logic          o_tx_valid,
    output logic [DW-1:0] o_tx_data,
    output logic          o_start_pattern_done,
    output logic          o_pattern_timeout,
    output logic          o_partner_detected
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int IW = $clog2(EXTRA_ITER + 1);

    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] ITER_MAX = IW'(EXTRA_ITER);
    localparam logic [7:0]    DET_MAX  = 8'(DETECT_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [IW-1:0] iter_cnt_q, iter_cnt_d;
    logic [7:0]    det_cnt_q, det_cnt_d;
    logic          detected_q, detected_d;
    logic          tx_valid_q, tx_valid_d;
    logic [DW-1:0] tx_data_q, tx_data_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        iter_cnt_d = iter_cnt_q;
        det_cnt_d  = det_cnt_q;
        detected_d = detected_q;
        tx_valid_d = tx_valid_q;

        // Detector is live only while the pattern exchange is running.
        if ((state_q == ST_SEND) || (state_q == ST_GAP)) begin
            if (i_rx_valid) begin
                if (i_rx_data == PATTERN) begin
                    if (det_cnt_q >= DET_MAX - 8'd1) begin
                        det_cnt_d  = DET_MAX;
                        detected_d = 1'b1;
                    end else begin
                        det_cnt_d = det_cnt_q + 8'd1;
                    end
                end else begin
                    det_cnt_d = 8'd0;
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                to_cnt_d   = '0;
                gap_cnt_d  = '0;
                iter_cnt_d = '0;
                det_cnt_d  = 8'd0;
                detected_d = 1'b0;
                tx_valid_d = 1'b0;
                if (i_start_pattern_req) begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (tx_valid_q && i_tx_ready) begin
                    state_d    = ST_GAP;
                    tx_valid_d = 1'b0;
                    gap_cnt_d  = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    // Registered detect flag is sampled here only; a detection
                    // landing in this very cycle is seen at the next gap end.
                    if (!detected_q) begin
                        state_d    = ST_SEND;
                        tx_valid_d = 1'b1;
                    end else if (iter_cnt_q < ITER_MAX) begin
                        state_d    = ST_SEND;
                        tx_valid_d = 1'b1;
                        iter_cnt_d = iter_cnt_q + IW'(1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                tx_valid_d = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        // Timeout runs across SEND/GAP; a same-cycle DONE takes precedence.
        if ((state_q == ST_SEND) || (state_q == ST_GAP)) begin
            if (to_cnt_q == TO_LAST) begin
                if (state_d != ST_DONE) begin
                    state_d    = ST_TIMEOUT;
                    tx_valid_d = 1'b0;
                end
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end

        // Enable low overrides everything and clears all bookkeeping with the state.
        if (!i_sbinit_en) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            to_cnt_d   = '0;
            gap_cnt_d  = '0;
            iter_cnt_d = '0;
            det_cnt_d  = 8'd0;
            detected_d = 1'b0;
        end

        tx_data_d = tx_valid_d ? PATTERN : '0;
        done_d    = (state_d == ST_DONE);
        timeout_d = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            iter_cnt_q <= '0;
            det_cnt_q  <= 8'd0;
            detected_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            iter_cnt_q <= iter_cnt_d;
            det_cnt_q  <= det_cnt_d;
            detected_q <= detected_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_tx_valid           = tx_valid_q;
    assign o_tx_data            = tx_data_q;
    assign o_start_pattern_done = done_q;
    assign o_pattern_timeout    = timeout_q;
    assign o_partner_detected   = detected_q;

endmodule
